// File: rtl/acc_pkg.sv
// acc_pkg: shared constants, matrix types and FSM states for the 3x3 matmul sequencer
package acc_pkg;
    localparam int DAT_SIZE = 8;
    localparam int RES_SIZE = 16;
    localparam int N_ELEM   = 9;
    localparam int IDX_W    = 4;
    typedef logic [N_ELEM-1:0][DAT_SIZE-1:0] operand_mat_t;
    typedef logic [N_ELEM-1:0][RES_SIZE-1:0] result_mat_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/acc_operand_buf.sv
// acc_operand_buf: dual A/B operand element register file with index-range check
module acc_operand_buf
    import acc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                sel,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DAT_SIZE-1:0] data,
    output logic                bad,
    output operand_mat_t        a,
    output operand_mat_t        b
);
    assign bad = idx >= IDX_W'(N_ELEM);
    // store accepted in-range writes into the selected matrix; out-of-range writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (we && !bad) begin
            if (sel) b[idx] <= data;
            else     a[idx] <= data;
        end
    end
endmodule

// File: rtl/acc_mm_ctrl.sv
// acc_mm_ctrl: sequencer that feeds operand buffers to the matmul datapath and captures results
module acc_mm_ctrl
    import acc_pkg::*;
#(
    parameter int MM_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       wr_sel,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DAT_SIZE-1:0]        wr_data,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [RES_SIZE-1:0]        rd_data,
    output logic [N_ELEM*DAT_SIZE-1:0] mm_a_o,
    output logic [N_ELEM*DAT_SIZE-1:0] mm_b_o,
    input  logic [N_ELEM*RES_SIZE-1:0] mm_c_i
);
    localparam int CNT_W = $clog2(MM_LATENCY + 1);

    if (MM_LATENCY < 1) begin : g_lat_check
        $error("acc_mm_ctrl: MM_LATENCY must be >= 1");
    end

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    result_mat_t      res;
    operand_mat_t     a, b;
    logic             wr_acc, bad, launch, capture;

    assign wr_acc  = wr_valid && wr_ready;
    assign launch  = state == IDLE && start_i;
    assign capture = state == RUN && cnt == '0;

    acc_operand_buf u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_acc),
        .sel  (wr_sel),
        .idx  (wr_idx),
        .data (wr_data),
        .bad  (bad),
        .a    (a),
        .b    (b)
    );

    assign mm_a_o  = a;
    assign mm_b_o  = b;
    assign rd_data = rd_idx < IDX_W'(N_ELEM) ? res[rd_idx] : '0;

    // next-state and per-state handshake/status outputs
    always_comb begin
        nxt      = state;
        wr_ready = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                nxt      = start_i ? RUN : IDLE;
            end
            RUN: begin
                busy_o = 1'b1;
                nxt    = cnt == '0 ? DONE : RUN;
            end
            DONE: begin
                done_o = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // latency counter, result capture and sticky index error (a bad write wins over a same-edge start)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            res   <= '0;
            err_o <= 1'b0;
        end else begin
            if (launch)            cnt <= CNT_W'(MM_LATENCY - 1);
            else if (state == RUN && cnt != '0) cnt <= cnt - 1'b1;
            if (capture)           res <= mm_c_i;
            if (wr_acc && bad)     err_o <= 1'b1;
            else if (launch)       err_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acc_mm_ctrl.sv
// tb_acc_mm_ctrl: randomized self-checking bench with a matrix-level reference model
module tb_acc_mm_ctrl;
    import acc_pkg::*;

    localparam int L = 2;

    logic                       clk = 1'b0, rst_n = 1'b0;
    logic                       wr_valid = 1'b0, wr_sel = 1'b0, start_i = 1'b0;
    logic [IDX_W-1:0]           wr_idx = '0, rd_idx = '0;
    logic [DAT_SIZE-1:0]        wr_data = '0;
    logic                       wr_ready, busy_o, done_o, err_o;
    logic [RES_SIZE-1:0]        rd_data;
    logic [N_ELEM*DAT_SIZE-1:0] mm_a_o, mm_b_o;
    logic [N_ELEM*RES_SIZE-1:0] mm_c_i;
    result_mat_t                dp_q [L-1];

    int           checks = 0, errors = 0;
    operand_mat_t exp_a = '0, exp_b = '0;
    result_mat_t  exp_res = '0;
    logic         exp_err = 1'b0;

    always #5 clk = ~clk;

    acc_mm_ctrl #(.MM_LATENCY(L)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .mm_a_o  (mm_a_o),
        .mm_b_o  (mm_b_o),
        .mm_c_i  (mm_c_i)
    );

    function automatic result_mat_t matmul(input operand_mat_t a, input operand_mat_t b);
        result_mat_t r;
        int s;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(a[i*3+k]) * int'(b[k*3+j]);
                r[i*3+j] = s[RES_SIZE-1:0];
            end
        return r;
    endfunction

    // datapath stand-in: product becomes valid L cycles after the operands settle
    always @(posedge clk) begin
        dp_q[0] <= matmul(mm_a_o, mm_b_o);
        for (int i = 1; i < L - 1; i++) dp_q[i] <= dp_q[i-1];
    end
    assign mm_c_i = dp_q[L-2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic sel, input int idx, input int data);
        if (idx >= N_ELEM) exp_err = 1'b1;
        else if (sel) exp_b[idx] = DAT_SIZE'(data);
        else exp_a[idx] = DAT_SIZE'(data);
    endtask

    task automatic wr(input logic sel, input int idx, input int data);
        logic acc;
        wr_valid = 1'b1; wr_sel = sel; wr_idx = IDX_W'(idx); wr_data = DAT_SIZE'(data);
        for (int n = 0; n < 20; n++) begin
            acc = wr_ready;
            tick();
            if (acc) begin
                model_wr(sel, idx, data);
                wr_valid = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
        check("wr_timeout", 1'b0, 1'b1);
    endtask

    task automatic read_all();
        for (int r = 0; r < 16; r++) begin
            rd_idx = IDX_W'(r);
            #1;
            check($sformatf("rd[%0d]", r), rd_data, r < N_ELEM ? exp_res[r] : '0);
        end
    endtask

    // blk: during RUN re-pulse start and hold a write of B[0]=7; sim: write together with start
    task automatic launch(input bit blk, input bit sim);
        logic acc;
        int   s_idx, s_dat;
        logic s_sel;
        start_i = 1'b1;
        if (sim) begin
            s_sel = 1'($urandom_range(0, 1)); s_idx = $urandom_range(0, 8); s_dat = $urandom_range(0, 255);
            wr_valid = 1'b1; wr_sel = s_sel; wr_idx = IDX_W'(s_idx); wr_data = DAT_SIZE'(s_dat);
            model_wr(s_sel, s_idx, s_dat);
        end
        exp_res = matmul(exp_a, exp_b);
        exp_err = 1'b0;
        tick();
        start_i = 1'b0;
        wr_valid = 1'b0;
        check("err_clr", err_o, exp_err);
        check("mm_a", mm_a_o, exp_a);
        check("mm_b", mm_b_o, exp_b);
        if (blk) begin
            start_i = 1'b1;
            wr_valid = 1'b1; wr_sel = 1'b1; wr_idx = '0; wr_data = 8'd7;
        end
        for (int c = 1; c <= L + 2; c++) begin
            check($sformatf("wr_ready@%0d", c), wr_ready, c == L + 2);
            check($sformatf("done@%0d", c), done_o, c == L + 1);
            check($sformatf("busy@%0d", c), busy_o, c <= L);
            if (blk) check($sformatf("b0_stall@%0d", c), mm_b_o[DAT_SIZE-1:0], exp_b[0]);
            acc = wr_ready;
            tick();
            if (c == 1) start_i = 1'b0;
            if (blk && wr_valid && acc) begin
                model_wr(1'b1, 0, 7);
                wr_valid = 1'b0;
            end
        end
        if (blk) begin
            check("b0_landed", mm_b_o[DAT_SIZE-1:0], 8'd7);
            check("b0_model", exp_b[0], 8'd7);
        end
        for (int c = 0; c < 3; c++) begin
            check("no_redone", done_o, 1'b0);
            check("no_rebusy", busy_o, 1'b0);
            tick();
        end
        read_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_mm_a", mm_a_o, '0);
        check("rst_mm_b", mm_b_o, '0);
        read_all();

        for (int i = 0; i < N_ELEM; i++) begin
            wr(1'b0, i, (i % 4 == 0) ? 1 : 0);
            wr(1'b1, i, i + 1);
        end
        launch(1'b0, 1'b0);
        for (int i = 0; i < N_ELEM; i++) check("ident_val", exp_res[i], RES_SIZE'(i + 1));

        for (int i = 0; i < N_ELEM; i++) begin
            wr(1'b0, i, 2);
            wr(1'b1, i, 3);
        end
        launch(1'b0, 1'b0);
        for (int i = 0; i < N_ELEM; i++) check("const_val", exp_res[i], RES_SIZE'(18));
        launch(1'b1, 1'b0);

        wr(1'b0, 12, 8'h55);
        check("bad_err", err_o, 1'b1);
        check("bad_err_model", exp_err, 1'b1);
        check("bad_mm_a", mm_a_o, exp_a);
        check("bad_mm_b", mm_b_o, exp_b);
        launch(1'b0, 1'b0);
        check("err_after", err_o, 1'b0);

        launch(1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < int'($urandom_range(1, 8)); w++)
                wr(1'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom_range(0, 255));
            check("rand_err", err_o, exp_err);
            check("rand_mm_a", mm_a_o, exp_a);
            check("rand_mm_b", mm_b_o, exp_b);
            launch(1'b0, r % 2 == 1);
        end

        wr(1'b0, 13, 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("mid_busy", busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_a = '0; exp_b = '0; exp_res = '0; exp_err = 1'b0;
        check("arst_busy", busy_o, 1'b0);
        check("arst_done", done_o, 1'b0);
        check("arst_err", err_o, 1'b0);
        check("arst_ready", wr_ready, 1'b1);
        check("arst_mm_a", mm_a_o, exp_a);
        check("arst_mm_b", mm_b_o, exp_b);
        read_all();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("arst_hold_done", done_o, 1'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        launch(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_mm_ctrl.md
Name: acc_mm_ctrl

Overview:
- Sequencer for the 3x3 matrix-multiply accelerator datapath.
- Holds operand buffers for A and B (9 x 8-bit each), loaded one element per handshake. On start it drives the buffers into the datapath and waits a fixed datapath latency, then captures the 9 x 16-bit result.
- Sits between a simple element-write/read host interface (driven by core-side glue) and the matrix-multiply datapath.

Parameters:
- DAT_SIZE, 8, operand element width.
- RES_SIZE, 16, result element width.
- N_ELEM, 9, elements per matrix (3x3).
- MM_LATENCY, 2, cycles from operand-stable to valid datapath output. Must be >= 1; an elaboration check fails otherwise.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  element write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_idx  in  4  element index, row-major, 0..8.
- wr_data  in  DAT_SIZE  element value.
- start_i  in  1  launch multiply (level sampled).
- busy_o  out  1  computation in progress.
- done_o  out  1  one-cycle pulse, results captured.
- err_o  out  1  sticky: out-of-range write index seen.
- rd_idx  in  4  result element index.
- rd_data  out  RES_SIZE  captured result element (combinational from result regs).
- mm_a_o  out  N_ELEM*DAT_SIZE  operand A to datapath.
- mm_b_o  out  N_ELEM*DAT_SIZE  operand B to datapath.
- mm_c_i  in  N_ELEM*RES_SIZE  datapath result.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All A/B buffers and result regs 0.
  - busy_o=0, done_o=0, err_o=0, counter 0.
  - wr_ready=1 in the first cycle after reset release.
- FSM states: IDLE, RUN, DONE.
  - IDLE: wr_ready=1. start_i=1 at a clock edge -> RUN, counter loaded with MM_LATENCY-1.
  - RUN: busy_o=1, wr_ready=0. Counter decrements each cycle. At the edge where counter==0, result regs <= mm_c_i and state -> DONE.
  - DONE: done_o=1 for exactly one cycle, wr_ready=0, busy_o=0. Next state IDLE.
- Timing: start_i high in cycle 0 gives:
  - busy_o high in cycles 1..MM_LATENCY;
  - done_o and new rd_data in cycle MM_LATENCY+1;
  - wr_ready back to 1 in cycle MM_LATENCY+2.
- Writes:
  - An accepted write with wr_idx<=8 updates buffer[wr_sel][wr_idx] at the clock edge.
  - An accepted write with wr_idx>=9 is discarded and sets err_o.
  - err_o clears on the edge that accepts start_i.
- Simultaneous write and start in IDLE: the write is applied on the same edge, so the new value is part of this computation.
- start_i while in RUN or DONE is ignored (no queuing). start_i held high continuously relaunches after each return to IDLE.
- wr_valid while wr_ready=0 is not accepted. The host holds the request; buffers are unchanged.
- mm_a_o/mm_b_o are driven directly from the buffers. They are stable throughout RUN because writes are blocked.
- rd_data:
  - rd_idx>=9 reads 0.
  - Result regs hold their value until the next capture, and are unaffected by operand writes.
- Reset mid-RUN: immediate return to IDLE with all registers cleared. No done_o pulse.

Decomposition:
- Package acc_pkg holds:
  - constants DAT_SIZE, RES_SIZE, N_ELEM, IDX_W=4;
  - typedefs operand_mat_t (packed [N_ELEM-1:0][DAT_SIZE-1:0]) and result_mat_t;
  - enum state_t {IDLE, RUN, DONE}.
- One natural sub-module: acc_operand_buf, the dual A/B element register file with index-range check. It is instantiated once, with write port and two flat outputs.
- FSM, counter and result capture stay in acc_mm_ctrl.

Test Plan:
- Reset values: after rst_n release, check busy_o=0, done_o=0, err_o=0, wr_ready=1, and rd_data=0 for all rd_idx.
- Identity multiply: load A=identity and B=1..9 row-major, pulse start -> done_o exactly in cycle MM_LATENCY+1; rd_idx 0..8 reads 1..9.
- Constant multiply: load A all 2 and B all 3, start -> every rd_data=18; busy_o high for exactly MM_LATENCY cycles.
- Blocking during RUN:
  - a write of B[0]=7 issued during RUN stalls with wr_ready=0 and lands only in cycle MM_LATENCY+2;
  - a second start during RUN produces no second done_o;
  - results still equal 18.
- Bad index: write with wr_idx=12 -> err_o=1 and no buffer changes; next start clears err_o; reading rd_idx=15 returns 0.
- Reset in middle of RUN: deassert rst_n in cycle 1 -> all outputs return to reset values asynchronously, no done_o, and all buffers read back 0 on a subsequent start.
